upsampling_stream_fifo: RTL and testbench

Parametrised synchronous FIFO with built-in flow-control thresholds for the TJPU upsampling write path. It replaces the vendor-IP FIFO with inferred simple-dual-port RAM, so width and depth are generic. It exposes the downstream threshold flag M_Ready and the upstream threshold flag S_Ready, using full-width arithmetic that cannot overflow. It adds full, data_count, sticky overflow/underflow flags and a dout_valid strobe.

---
 rtl/upsampling_fifo_pkg.sv | 29 ++
 rtl/upsampling_fifo_ram.sv | 50 +++++
 rtl/upsampling_stream_fifo.sv | 138 +++++++++++++
 tb/tb_upsampling_stream_fifo.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/upsampling_fifo_pkg.sv
// rtl/upsampling_fifo_pkg.sv - shared sizing and threshold helpers for the upsampling write-path FIFO
package upsampling_fifo_pkg;

    localparam int unsigned DEFAULT_ADDR_BITS = 9;

    // Width of an occupancy counter able to hold 0..2**addr_bits inclusive.
    function automatic int unsigned cnt_w(input int unsigned addr_bits);
        return addr_bits + 1;
    endfunction

    function automatic int unsigned depth_of(input int unsigned addr_bits);
        return 32'd1 << addr_bits;
    endfunction

    localparam int unsigned DEFAULT_DEPTH = depth_of(DEFAULT_ADDR_BITS);

    // Consumer may start a burst once enough words are buffered.
    function automatic logic m_ready_calc(input int unsigned count, input int unsigned need);
        return count >= need;
    endfunction

    // Producer may start a burst if its words fit with slack to spare.
    // The slack is added on the left so depth - slack can never wrap below zero.
    function automatic logic s_ready_calc(input int unsigned sum, input int unsigned depth,
                                          input int unsigned slack);
        return (sum + slack) <= depth;
    endfunction

endpackage

// File: rtl/upsampling_fifo_ram.sv
// rtl/upsampling_fifo_ram.sv - inferred simple-dual-port RAM with a registered, resettable read port
module upsampling_fifo_ram
    import upsampling_fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = 128,
    parameter int unsigned ADDR_BITS = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);

    localparam int unsigned DEPTH = depth_of(ADDR_BITS);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_d;
    logic [WIDTH-1:0] rdata_q;

    // Write port: storage array is never cleared, only overwritten.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read data holds its last value unless a read is issued.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    // Output register; reset clears only the presented word, not the array.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/upsampling_stream_fifo.sv
// rtl/upsampling_stream_fifo.sv - threshold-flagged sync FIFO; UPSAMPLE_FIFO_FWFT_EN selects fall-through read
module upsampling_stream_fifo
    import upsampling_fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = 128,
    parameter int unsigned ADDR_BITS = 9,
    parameter int unsigned S_SLACK   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     din,
    input  logic                 wr_en,
    input  logic                 rd_en,
    output logic [WIDTH-1:0]     dout,
    output logic                 dout_valid,
    output logic                 empty,
    output logic                 full,
    output logic [ADDR_BITS:0]   data_count,
    input  logic [ADDR_BITS:0]   M_count,
    output logic                 M_Ready,
    input  logic [ADDR_BITS:0]   S_count,
    output logic                 S_Ready,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int unsigned          DEPTH    = depth_of(ADDR_BITS);
    localparam int unsigned          CW       = cnt_w(ADDR_BITS);
    localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]        CNT_FULL = CW'(DEPTH);
    localparam logic [ADDR_BITS-1:0] PTR_ONE  = ADDR_BITS'(1);

    logic [ADDR_BITS-1:0] wr_ptr_d, wr_ptr_q;
    logic [ADDR_BITS-1:0] rd_ptr_d, rd_ptr_q;
    logic [CW-1:0]        data_count_d, data_count_q;
    logic                 empty_d, empty_q;
    logic                 full_d, full_q;
    logic                 dout_valid_d, dout_valid_q;
    logic                 m_ready_d, m_ready_q;
    logic                 s_ready_d, s_ready_q;
    logic                 overflow_d, overflow_q;
    logic                 underflow_d, underflow_q;

    logic                 wr_acc;
    logic                 pop;
    logic                 ram_re;
    logic [ADDR_BITS+1:0] s_sum;
`ifdef UPSAMPLE_FIFO_FWFT_EN
    logic [CW-1:0]        ram_count;
`endif

    // Next-state for pointers, occupancy, status flags and threshold flags.
    always_comb begin
        wr_acc = wr_en & ~full_q;
`ifdef UPSAMPLE_FIFO_FWFT_EN
        // The RAM output register acts as the prefetch slot; it is refilled
        // whenever it is empty or being popped and the RAM still holds words.
        ram_count    = data_count_q - CW'(dout_valid_q);
        pop          = rd_en & dout_valid_q;
        ram_re       = (ram_count != '0) & (~dout_valid_q | pop);
        dout_valid_d = ram_re | (dout_valid_q & ~pop);
`else
        pop          = rd_en & ~empty_q;
        ram_re       = pop;
        dout_valid_d = pop;
`endif
        wr_ptr_d = wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = ram_re ? rd_ptr_q + PTR_ONE : rd_ptr_q;

        data_count_d = data_count_q;
        if (wr_acc && !pop) begin
            data_count_d = data_count_q + CNT_ONE;
        end else if (pop && !wr_acc) begin
            data_count_d = data_count_q - CNT_ONE;
        end
        empty_d = (data_count_d == '0);
        full_d  = (data_count_d == CNT_FULL);

        // One extra bit so count + S_count cannot wrap.
        s_sum     = {1'b0, data_count_q} + {1'b0, S_count};
        m_ready_d = m_ready_calc(32'(data_count_q), 32'(M_count));
        s_ready_d = s_ready_calc(32'(s_sum), DEPTH, S_SLACK);

        overflow_d  = overflow_q  | (wr_en & full_q);
        underflow_d = underflow_q | (rd_en & empty_q);
    end

    // State register with synchronous reset; reset discards stored words.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            data_count_q <= '0;
            empty_q      <= 1'b1;
            full_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            m_ready_q    <= 1'b0;
            s_ready_q    <= 1'b1;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            data_count_q <= data_count_d;
            empty_q      <= empty_d;
            full_q       <= full_d;
            dout_valid_q <= dout_valid_d;
            m_ready_q    <= m_ready_d;
            s_ready_q    <= s_ready_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    upsampling_fifo_ram #(
        .WIDTH     (WIDTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc & ~rst),
        .waddr (wr_ptr_q),
        .wdata (din),
        .re    (ram_re & ~rst),
        .raddr (rd_ptr_q),
        .rdata (dout)
    );

    assign dout_valid = dout_valid_q;
    assign empty      = empty_q;
    assign full       = full_q;
    assign data_count = data_count_q;
    assign M_Ready    = m_ready_q;
    assign S_Ready    = s_ready_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_upsampling_stream_fifo.sv
// tb/tb_upsampling_stream_fifo.sv - self-checking bench for upsampling_stream_fifo (standard read mode)
module tb_upsampling_stream_fifo;

    localparam int WIDTH     = 32;
    localparam int ADDR_BITS = 9;
    localparam int DEPTH     = 512;
    localparam int S_SLACK   = 1;

    logic                 clk;
    logic                 rst;
    logic [WIDTH-1:0]     din;
    logic                 wr_en;
    logic                 rd_en;
    logic [WIDTH-1:0]     dout;
    logic                 dout_valid;
    logic                 empty;
    logic                 full;
    logic [ADDR_BITS:0]   data_count;
    logic [ADDR_BITS:0]   M_count;
    logic                 M_Ready;
    logic [ADDR_BITS:0]   S_count;
    logic                 S_Ready;
    logic                 overflow;
    logic                 underflow;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    // Reference model state
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] exp_dout;
    logic             exp_dv, exp_mr, exp_sr, exp_ov, exp_un;

    upsampling_stream_fifo #(
        .WIDTH     (WIDTH),
        .ADDR_BITS (ADDR_BITS),
        .S_SLACK   (S_SLACK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .dout       (dout),
        .dout_valid (dout_valid),
        .empty      (empty),
        .full       (full),
        .data_count (data_count),
        .M_count    (M_count),
        .M_Ready    (M_Ready),
        .S_count    (S_count),
        .S_Ready    (S_Ready),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of stored words plus the registered flags.
    always @(posedge clk) begin
        int n;
        if (rst) begin
            mq.delete();
            exp_dout = '0;
            exp_dv   = 1'b0;
            exp_mr   = 1'b0;
            exp_sr   = 1'b1;
            exp_ov   = 1'b0;
            exp_un   = 1'b0;
        end else begin
            n      = mq.size();
            exp_mr = (n >= int'(M_count));
            exp_sr = ((n + int'(S_count) + S_SLACK) <= DEPTH);
            if (wr_en && n == DEPTH) exp_ov = 1'b1;
            if (rd_en && n == 0)     exp_un = 1'b1;
            exp_dv = 1'b0;
            if (rd_en && n > 0) begin
                exp_dout = mq.pop_front();
                exp_dv   = 1'b1;
            end
            if (wr_en && n < DEPTH) mq.push_back(din);
        end
    end

    // Compare all outputs against the model every cycle, away from the edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("data_count", 64'(data_count), 64'(mq.size()));
            check("empty",      64'(empty),      64'(mq.size() == 0));
            check("full",       64'(full),       64'(mq.size() == DEPTH));
            check("dout",       64'(dout),       64'(exp_dout));
            check("dout_valid", 64'(dout_valid), 64'(exp_dv));
            check("M_Ready",    64'(M_Ready),    64'(exp_mr));
            check("S_Ready",    64'(S_Ready),    64'(exp_sr));
            check("overflow",   64'(overflow),   64'(exp_ov));
            check("underflow",  64'(underflow),  64'(exp_un));
        end
    end

    task automatic step(input logic w, input logic r, input logic [WIDTH-1:0] d);
        wr_en = w;
        rd_en = r;
        din   = d;
        @(negedge clk);
    endtask

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        din     = '0;
        M_count = 10'd4;
        S_count = 10'd16;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 0);
        step(0, 0, 0);
        check("idle_M_Ready", 64'(M_Ready), 64'd0);
        check("idle_S_Ready", 64'(S_Ready), 64'd1);
        check("idle_empty",   64'(empty),   64'd1);
        check("idle_count",   64'(data_count), 64'd0);

        // Four writes, then M_Ready one cycle after the count reaches 4
        for (int i = 1; i <= 4; i++) step(1, 0, WIDTH'(i));
        check("w4_count",   64'(data_count), 64'd4);
        check("w4_M_early", 64'(M_Ready),    64'd0);
        step(0, 0, 0);
        check("w4_M_Ready", 64'(M_Ready),    64'd1);
        for (int i = 1; i <= 4; i++) begin
            step(0, 1, 0);
            check("r4_dout",  64'(dout),       64'(i));
            check("r4_valid", 64'(dout_valid), 64'd1);
        end
        step(0, 0, 0);
        check("r4_valid_drop", 64'(dout_valid), 64'd0);

        // S_Ready threshold near the top
        S_count = 10'd1;
        for (int i = 0; i < 511; i++) step(1, 0, WIDTH'(32'h1000 + i));
        check("f511_count", 64'(data_count), 64'd511);
        step(0, 0, 0);
        check("f511_S_Ready", 64'(S_Ready), 64'd0);
        step(0, 1, 0);
        check("f510_count", 64'(data_count), 64'd510);
        step(0, 0, 0);
        check("f510_S_Ready", 64'(S_Ready), 64'd1);

        // Full, then write+read: read wins, write dropped
        step(1, 0, 32'hBEEF0001);
        step(1, 0, 32'hBEEF0002);
        step(0, 0, 0);
        check("full_flag", 64'(full), 64'd1);
        step(1, 1, 32'hDEADDEAD);
        check("ovf_count", 64'(data_count), 64'd511);
        check("ovf_flag",  64'(overflow),   64'd1);
        step(0, 0, 0);
        check("ovf_sticky", 64'(overflow),  64'd1);

        // Drain, then a burst request larger than the free space
        for (int i = 0; i < 511; i++) step(0, 1, 0);
        check("drain_empty", 64'(empty), 64'd1);
        S_count = 10'd512;
        step(0, 0, 0);
        step(0, 0, 0);
        check("s512_S_Ready", 64'(S_Ready), 64'd0);
        S_count = 10'd511;
        step(0, 0, 0);
        check("s511_S_Ready", 64'(S_Ready), 64'd1);

        // Read while empty alongside a write
        step(1, 1, 32'h000000AA);
        check("udf_count", 64'(data_count), 64'd1);
        check("udf_flag",  64'(underflow),  64'd1);
        check("udf_valid", 64'(dout_valid), 64'd0);

        // Mixed random traffic; first half biased to write, second to read
        for (int i = 0; i < 1500; i++) begin
            M_count = 10'($urandom_range(0, 512));
            S_count = 10'($urandom_range(0, 512));
            if (i < 750)
                step(($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 40), $urandom);
            else
                step(($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 70), $urandom);
        end

        // Reset in the middle of traffic
        for (int i = 0; i < 5; i++) step(1, 0, WIDTH'(32'h5000 + i));
        rst   = 1'b1;
        wr_en = 1'b1;
        rd_en = 1'b1;
        @(negedge clk);
        check("rst_count",     64'(data_count), 64'd0);
        check("rst_empty",     64'(empty),      64'd1);
        check("rst_full",      64'(full),       64'd0);
        check("rst_dout",      64'(dout),       64'd0);
        check("rst_valid",     64'(dout_valid), 64'd0);
        check("rst_M_Ready",   64'(M_Ready),    64'd0);
        check("rst_S_Ready",   64'(S_Ready),    64'd1);
        check("rst_overflow",  64'(overflow),   64'd0);
        check("rst_underflow", 64'(underflow),  64'd0);
        rst = 1'b0;
        step(0, 0, 0);
        step(0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
